// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: default FIFO geometry, flag thresholds and pointer/count width helpers.
package async_fifo_pkg;
    localparam int DATA_WIDTH      = 8;
    localparam int DEPTH           = 16;
    localparam int ALMOST_FULL_TH  = DEPTH - 2;
    localparam int ALMOST_EMPTY_TH = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/async_fifo_8b_mem.sv
// fifo_mem: dual-port register array, synchronous write, asynchronous read.
module fifo_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/async_fifo_8b.sv
// async_fifo_8b: single-clock byte FIFO with registered read data and five status flags.
// Define ASYNC_FIFO_FWFT_EN for first-word fall-through output.
module async_fifo_8b #(
    parameter int DATA_WIDTH      = async_fifo_pkg::DATA_WIDTH,
    parameter int DEPTH           = async_fifo_pkg::DEPTH,
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = async_fifo_pkg::ALMOST_EMPTY_TH
) (
    input  logic                  w_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  r_en,
    input  logic                  w_en,
    input  logic                  r_clk,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  f_full_flag,
    output logic                  f_half_full_flag,
    output logic                  f_empty_flag,
    output logic                  f_almost_full_flag,
    output logic                  f_almost_empty_flag
);
    import async_fifo_pkg::*;

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [1:0]            sync_q, sync_d;
    logic                  rst_n;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  do_wr, do_rd;
    logic                  unused_r_clk;

    assign unused_r_clk = r_clk;

    // Assert immediately, release two edges later so all state leaves reset together.
    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign rst_n = sync_q[1];

    always_comb begin
        sync_d   = {sync_q[0], 1'b1};
        do_wr    = w_en && !f_full_flag;
        do_rd    = r_en && !f_empty_flag;
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(.W(DATA_WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
        .clk   (w_clk),
        .we    (do_wr),
        .waddr (wr_ptr_q),
        .wdata (d_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

`ifdef ASYNC_FIFO_FWFT_EN
    assign d_out = f_empty_flag ? '0 : rdata;
`else
    logic [DATA_WIDTH-1:0] d_out_q, d_out_d;

    always_comb d_out_d = do_rd ? rdata : d_out_q;

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) d_out_q <= '0;
        else        d_out_q <= d_out_d;
    end

    assign d_out = d_out_q;
`endif

    assign f_full_flag         = count_q == CW'(DEPTH);
    assign f_half_full_flag    = count_q >= CW'(DEPTH / 2);
    assign f_empty_flag        = count_q == '0;
    assign f_almost_full_flag  = count_q >= CW'(ALMOST_FULL_TH);
    assign f_almost_empty_flag = count_q <= CW'(ALMOST_EMPTY_TH);
endmodule

// File: tb/tb_async_fifo_8b.sv
// tb_async_fifo_8b: directed and random stimulus against a queue-based reference model.
module tb_async_fifo_8b;
    localparam int DEPTH = 16;

    logic       w_clk = 1'b0, r_clk = 1'b0, reset = 1'b0;
    logic [7:0] d_in = '0;
    logic       r_en = 1'b0, w_en = 1'b0;
    logic [7:0] d_out;
    logic       f_full_flag, f_half_full_flag, f_empty_flag;
    logic       f_almost_full_flag, f_almost_empty_flag;

    int         checks = 0, failures = 0;
    logic [7:0] q[$];
    logic [7:0] dout_m = '0;

    always #5 w_clk = ~w_clk;

    async_fifo_8b dut (
        .w_clk               (w_clk),
        .reset               (reset),
        .d_in                (d_in),
        .r_en                (r_en),
        .w_en                (w_en),
        .r_clk               (r_clk),
        .d_out               (d_out),
        .f_full_flag         (f_full_flag),
        .f_half_full_flag    (f_half_full_flag),
        .f_empty_flag        (f_empty_flag),
        .f_almost_full_flag  (f_almost_full_flag),
        .f_almost_empty_flag (f_almost_empty_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_dout();
`ifdef ASYNC_FIFO_FWFT_EN
        return q.size() != 0 ? q[0] : 8'h00;
`else
        return dout_m;
`endif
    endfunction

    task automatic check_all(input string tag);
        int n = q.size();
        chk({tag, ".empty"}, 32'(f_empty_flag), 32'(n == 0));
        chk({tag, ".full"}, 32'(f_full_flag), 32'(n == DEPTH));
        chk({tag, ".half"}, 32'(f_half_full_flag), 32'(n >= DEPTH / 2));
        chk({tag, ".afull"}, 32'(f_almost_full_flag), 32'(n >= DEPTH - 2));
        chk({tag, ".aempty"}, 32'(f_almost_empty_flag), 32'(n <= 2));
        chk({tag, ".dout"}, 32'(d_out), 32'(exp_dout()));
    endtask

    task automatic cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
        logic [7:0] v;
        @(negedge w_clk);
        w_en = w; r_en = r; d_in = d;
        @(posedge w_clk);
        if (r && q.size() != 0) begin
            v = q.pop_front();
            dout_m = v;
        end else if (w && q.size() < DEPTH) begin
            q.push_back(d);
        end
        if (w && r && q.size() < DEPTH && (q.size() != 0 || v !== 8'hxx)) begin
        end
        #1 check_all(tag);
    endtask

    task automatic op(input string tag, input logic w, input logic r, input logic [7:0] d);
        logic [7:0] v;
        logic wr, rd;
        @(negedge w_clk);
        w_en = w; r_en = r; d_in = d;
        wr = w && q.size() < DEPTH;
        rd = r && q.size() != 0;
        @(posedge w_clk);
        if (rd) begin
            v = q.pop_front();
            dout_m = v;
        end
        if (wr) q.push_back(d);
        #1 check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        w_en = 0; r_en = 0;
        reset = 1'b0;
        q.delete();
        dout_m = '0;
        repeat (2) @(posedge w_clk);
        #1 check_all("rst_low");
        @(negedge w_clk);
        reset = 1'b1;
        repeat (3) op("rst_rel", 0, 0, 0);
    endtask

    initial begin
        do_reset();
        for (int i = 1; i <= 16; i++) op("fill", 1, 0, 8'(i));
        op("drop", 1, 0, 8'hFF);
        for (int i = 0; i < 16; i++) op("drain", 0, 1, 0);
        chk("drain_last", 32'(d_out), 32'h10);
        op("rd_empty", 0, 1, 0);
        chk("rd_empty_hold", 32'(d_out), 32'h10);
        for (int i = 0; i < 5; i++) op("pre5", 1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            op("rw5", 1, 1, 8'(8'h80 + i));
            chk("rw5_count", 32'(q.size()), 32'd5);
        end
        for (int i = 0; i < 400; i++)
            op("rand", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), 8'($urandom));
        for (int i = 0; i < 20; i++) op("rand_fill", 1, ($urandom_range(0, 3) == 0), 8'($urandom));
        for (int i = 0; i < 20; i++) op("rand_rw", 1, 1, 8'($urandom));
        for (int i = 0; i < 20; i++) op("rand_drain", ($urandom_range(0, 3) == 0), 1, 8'($urandom));
        do_reset();
        for (int i = 0; i < 3; i++) op("pre_abort", 1, 0, 8'(8'hC0 + i));
        @(negedge w_clk);
        w_en = 0; r_en = 0;
        #2 reset = 1'b0;
        q.delete();
        dout_m = '0;
        #1 check_all("abort_now");
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        reset = 1'b1;
        repeat (3) op("abort_rel", 0, 0, 0);
        for (int i = 0; i < 3; i++) op("abort_rd", 0, 1, 0);
        chk("abort_dout", 32'(d_out), 32'h0);
`ifdef ASYNC_FIFO_FWFT_EN
        op("fwft_wr", 1, 0, 8'hA5);
        chk("fwft_show", 32'(d_out), 32'hA5);
        op("fwft_rd", 0, 1, 0);
        chk("fwft_empty", 32'(f_empty_flag), 32'd1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
